// File: rtl/sd_sector_writer_if.sv
// rtl/sd_sector_writer_if.sv - write-side handshake bundle between sector writer and SD controller
interface sd_sector_writer_if;
    logic        sd_ready;
    logic        sd_ready_for_next_byte;
    logic        sd_wr;
    logic [7:0]  sd_din;
    logic [31:0] sd_address;

    modport master (
        input  sd_ready,
        input  sd_ready_for_next_byte,
        output sd_wr,
        output sd_din,
        output sd_address
    );

    modport slave (
        output sd_ready,
        output sd_ready_for_next_byte,
        input  sd_wr,
        input  sd_din,
        input  sd_address
    );
endinterface

// File: rtl/sd_sector_writer.sv
// rtl/sd_sector_writer.sv - buffers one sector and streams it to an SD controller
// Optional running byte checksum enabled by defining SDW_CHECKSUM_EN.
module sd_sector_writer #(
    parameter int SECTOR_BYTES = 512
) (
    input  logic               CLOCK_50,
    input  logic               KEY0,
    input  logic               buf_we,
    input  logic [8:0]         buf_addr,
    input  logic [7:0]         buf_wdata,
    input  logic               sect_we,
    input  logic [31:0]        sect_wdata,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [9:0]         byte_count,
    output logic [15:0]        checksum,
    sd_sector_writer_if.master sd
);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, REQ, STREAM, WAIT_DONE} state_t;

    localparam logic [9:0] LAST_BYTE = 10'(SECTOR_BYTES - 1);

    state_t      state;
    logic [7:0]  mem [SECTOR_BYTES];
    logic [31:0] sect_q;
    logic        req_q;
    logic        req_rise;

    assign req_rise      = sd.sd_ready_for_next_byte & ~req_q;
    assign sd.sd_address = sect_q;

    // Buffer is host-owned only while idle; no reset so contents survive KEY0.
    always_ff @(posedge CLOCK_50) begin
        if (buf_we && !busy)
            mem[buf_addr] <= buf_wdata;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sect_q    <= '0;
            sd.sd_din <= '0;
        end else begin
            sd.sd_din <= mem[byte_count[8:0]];
            if (sect_we && !busy)
                sect_q <= sect_wdata;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sd.sd_wr   <= 1'b0;
            byte_count <= '0;
            req_q      <= 1'b0;
`ifdef SDW_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            req_q <= sd.sd_ready_for_next_byte;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        byte_count <= '0;
`ifdef SDW_CHECKSUM_EN
                        checksum   <= '0;
`endif
                        if (sd.sd_ready) begin
                            state    <= REQ;
                            sd.sd_wr <= 1'b1;
                        end else begin
                            state <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (sd.sd_ready) begin
                        state    <= REQ;
                        sd.sd_wr <= 1'b1;
                    end
                end
                // The controller drops sd_ready once it has accepted the write command.
                REQ: begin
                    if (!sd.sd_ready) begin
                        state    <= STREAM;
                        sd.sd_wr <= 1'b0;
                    end
                end
                STREAM: begin
                    if (req_rise) begin
                        byte_count <= byte_count + 10'd1;
`ifdef SDW_CHECKSUM_EN
                        checksum   <= checksum + {8'd0, sd.sd_din};
`endif
                        if (byte_count == LAST_BYTE)
                            state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (sd.sd_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SDW_CHECKSUM_EN
    assign checksum = 16'd0;
`endif

endmodule
